// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the line master.
// Contents: A/D channel opcodes, beat width and the master FSM state encoding.
package tl_pkg;

    localparam int unsigned BEAT_W = 128;

    // Channel A opcodes
    localparam logic [2:0] A_PUT_FULL = 3'd0;
    localparam logic [2:0] A_GET      = 3'd4;

    // Channel D opcodes
    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;

    // Master FSM states
    typedef logic [2:0] state_t;
    localparam state_t StIdle    = 3'd0;
    localparam state_t StPut     = 3'd1;
    localparam state_t StPutAck  = 3'd2;
    localparam state_t StGet     = 3'd3;
    localparam state_t StGetData = 3'd4;
    localparam state_t StRsp     = 3'd5;

endpackage

// File: rtl/tl_line_mst.sv
// TileLink-UL line master: moves one cache line between a local requester and
// a TileLink slave. Writes are a PutFullData burst answered by one AccessAck;
// reads are a single Get whose AccessAckData beats fill the line buffer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (req_wr, req_addr, req_wdata)
//   rsp_valid/rsp_ready      completion handshake (rsp_rdata, rsp_err)
//   tlmst_a_*                TileLink channel A (master -> slave)
//   tlmst_d_*                TileLink channel D (slave -> master)
// All outputs decode from registered state, counter and buffer only.
module tl_line_mst
    import tl_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 4,
    parameter logic [2:0]  SRC_ID     = 3'd0
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_wr,
    input  logic [31:0]                  req_addr,
    input  logic [BEAT_W*LINE_BEATS-1:0] req_wdata,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [BEAT_W*LINE_BEATS-1:0] rsp_rdata,
    output logic                         rsp_err,

    output logic [2:0]                   tlmst_a_opcode,
    output logic [2:0]                   tlmst_a_param,
    output logic [7:0]                   tlmst_a_size,
    output logic [2:0]                   tlmst_a_source,
    output logic [31:0]                  tlmst_a_address,
    output logic [15:0]                  tlmst_a_mask,
    output logic [BEAT_W-1:0]            tlmst_a_data,
    output logic                         tlmst_a_corrupt,
    output logic                         tlmst_a_valid,
    input  logic                         tlmst_a_ready,

    input  logic [2:0]                   tlmst_d_opcode,
    input  logic [1:0]                   tlmst_d_param,
    input  logic [7:0]                   tlmst_d_size,
    input  logic [2:0]                   tlmst_d_source,
    input  logic [2:0]                   tlmst_d_sink,
    input  logic                         tlmst_d_denied,
    input  logic [BEAT_W-1:0]            tlmst_d_data,
    input  logic                         tlmst_d_corrupt,
    input  logic                         tlmst_d_valid,
    output logic                         tlmst_d_ready
);

    localparam int unsigned CNT_W = $clog2(LINE_BEATS) + 1;
    localparam int unsigned IDX_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(16 * LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [31:0]        addr_q, addr_d;
    logic [BEAT_W-1:0]  buf_q [LINE_BEATS];
    logic [BEAT_W-1:0]  buf_d [LINE_BEATS];
    logic [IDX_W-1:0]   idx;

    assign idx = cnt_q[IDX_W-1:0];

    // Fields the master never looks at.
    logic unused_in;
    assign unused_in = ^{tlmst_d_param, tlmst_d_size, tlmst_d_source, tlmst_d_sink,
                         req_addr[OFF_W-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        addr_d  = addr_q;
        buf_d   = buf_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                    for (int i = 0; i < LINE_BEATS; i++) begin
                        buf_d[i] = req_wdata[BEAT_W*i +: BEAT_W];
                    end
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = req_wr ? StPut : StGet;
                end
            end
            StPut: begin
                if (tlmst_a_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = StPutAck;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StPutAck: begin
                if (tlmst_d_valid) begin
                    if (tlmst_d_opcode == D_ACK) begin
                        err_d   = err_q | tlmst_d_denied | tlmst_d_corrupt;
                        state_d = StRsp;
                    end else begin
                        // Stray beat: swallow it but flag the transaction.
                        err_d = 1'b1;
                    end
                end
            end
            StGet: begin
                if (tlmst_a_ready) begin
                    state_d = StGetData;
                end
            end
            StGetData: begin
                if (tlmst_d_valid) begin
                    if (tlmst_d_opcode == D_ACK_DATA) begin
                        buf_d[idx] = tlmst_d_data;
                        err_d      = err_q | tlmst_d_denied | tlmst_d_corrupt;
                        if (cnt_q == LAST_BEAT) begin
                            cnt_d   = '0;
                            state_d = StRsp;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            for (int i = 0; i < LINE_BEATS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            for (int i = 0; i < LINE_BEATS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    // Channel A
    assign tlmst_a_valid   = (state_q == StPut) || (state_q == StGet);
    assign tlmst_a_opcode  = (state_q == StGet) ? A_GET : A_PUT_FULL;
    assign tlmst_a_param   = 3'd0;
    assign tlmst_a_size    = 8'(OFF_W);
    assign tlmst_a_source  = SRC_ID;
    assign tlmst_a_address = tlmst_a_valid ? addr_q : 32'd0;
    assign tlmst_a_mask    = tlmst_a_valid ? 16'hFFFF : 16'h0000;
    assign tlmst_a_data    = (state_q == StPut) ? buf_q[idx] : '0;
    assign tlmst_a_corrupt = 1'b0;

    // Channel D
    assign tlmst_d_ready = (state_q == StPutAck) || (state_q == StGetData);

    // Requester side
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StRsp);
    assign rsp_err   = err_q;

    for (genvar g = 0; g < LINE_BEATS; g++) begin : g_rdata
        assign rsp_rdata[BEAT_W*g +: BEAT_W] = buf_q[g];
    end

endmodule

// File: tb/tb_tl_line_mst.sv
// Self-checking bench for tl_line_mst: a TileLink memory slave with random
// stalls, a transaction-level reference model and a per-cycle compare process.
module tb_tl_line_mst;

    localparam int LB = 4;
    localparam int LW = 128 * LB;

    typedef struct packed {
        logic [2:0]   op;
        logic [31:0]  addr;
        logic [127:0] data;
    } abeat_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [127:0] data;
        logic         denied;
        logic         corrupt;
    } dbeat_t;

    logic          clk, rst;
    logic          req_valid, req_ready, req_wr;
    logic [31:0]   req_addr;
    logic [LW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [LW-1:0] rsp_rdata;
    logic [2:0]    a_opcode, a_param, a_source;
    logic [7:0]    a_size;
    logic [31:0]   a_address;
    logic [15:0]   a_mask;
    logic [127:0]  a_data;
    logic          a_corrupt, a_valid, a_ready;
    logic [2:0]    d_opcode, d_source, d_sink;
    logic [1:0]    d_param;
    logic [7:0]    d_size;
    logic          d_denied, d_corrupt, d_valid, d_ready;
    logic [127:0]  d_data;

    tl_line_mst #(.LINE_BEATS(LB), .SRC_ID(3'd0)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_wr          (req_wr),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .tlmst_a_opcode  (a_opcode),
        .tlmst_a_param   (a_param),
        .tlmst_a_size    (a_size),
        .tlmst_a_source  (a_source),
        .tlmst_a_address (a_address),
        .tlmst_a_mask    (a_mask),
        .tlmst_a_data    (a_data),
        .tlmst_a_corrupt (a_corrupt),
        .tlmst_a_valid   (a_valid),
        .tlmst_a_ready   (a_ready),
        .tlmst_d_opcode  (d_opcode),
        .tlmst_d_param   (d_param),
        .tlmst_d_size    (d_size),
        .tlmst_d_source  (d_source),
        .tlmst_d_sink    (d_sink),
        .tlmst_d_denied  (d_denied),
        .tlmst_d_data    (d_data),
        .tlmst_d_corrupt (d_corrupt),
        .tlmst_d_valid   (d_valid),
        .tlmst_d_ready   (d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave memory (written by DUT beats) and reference memory (written by requests).
    logic [127:0] smem    [logic [31:0]];
    logic [127:0] ref_mem [logic [31:0]];

    abeat_t        a_exp[$];
    dbeat_t        d_q[$];
    bit            outstanding = 0;
    int            d_rem = 0;
    logic [2:0]    exp_dop;
    logic [LW-1:0] exp_rdata;
    logic          exp_err;
    int            deny_beat = -1;
    bit            inject_bad = 0;
    int            cur_deny = -1;
    bit            cur_bad = 0;
    bit            stall_en = 0;
    int            put_cnt = 0;
    int            a_fire_cnt = 0;
    bit            stab_vld = 0;
    logic [178:0]  stab_val;

    // Channel drivers: random a_ready, D beats from the slave queue.
    always @(negedge clk) begin
        a_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (d_q.size() > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
            d_valid   = 1'b1;
            d_opcode  = d_q[0].op;
            d_data    = d_q[0].data;
            d_denied  = d_q[0].denied;
            d_corrupt = d_q[0].corrupt;
        end else begin
            d_valid   = 1'b0;
            d_opcode  = 3'($urandom);
            d_data    = {$urandom, $urandom, $urandom, $urandom};
            d_denied  = 1'($urandom);
            d_corrupt = 1'($urandom);
        end
        d_param  = 2'($urandom);
        d_size   = 8'($urandom);
        d_source = 3'($urandom);
        d_sink   = 3'($urandom);
    end

    // Compare process + slave model, sampled mid-cycle after inputs settle.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            a_exp.delete();
            d_q.delete();
            outstanding = 0;
            d_rem       = 0;
            put_cnt     = 0;
            stab_vld    = 0;
        end else begin
            chk("req_ready", req_ready, !outstanding);
            chk("a_valid", a_valid, a_exp.size() > 0);
            chk("d_ready", d_ready, outstanding && a_exp.size() == 0 && d_rem > 0);
            chk("rsp_valid", rsp_valid, outstanding && a_exp.size() == 0 && d_rem == 0);
            chk("a_const", {a_param, a_size, a_source, a_corrupt}, {3'd0, 8'd6, 3'd0, 1'b0});
            if (stab_vld) begin
                chk("a_stall_valid", a_valid, 1'b1);
                chk("a_stall_fields", {a_opcode, a_address, a_mask, a_data}, stab_val);
            end
            stab_vld = a_valid && !a_ready;
            stab_val = {a_opcode, a_address, a_mask, a_data};

            if (a_valid && a_ready) begin
                a_fire_cnt++;
                if (a_exp.size() > 0) begin
                    abeat_t e;
                    e = a_exp.pop_front();
                    chk("a_beat", {a_opcode, a_address, a_mask, a_data},
                        {e.op, e.addr, 16'hFFFF, e.data});
                end
                if (a_opcode == 3'd0) begin
                    smem[(a_address >> 4) + 32'(put_cnt)] = a_data;
                    put_cnt++;
                    if (put_cnt == LB) begin
                        put_cnt = 0;
                        d_q.push_back({3'd0, 128'd0, 1'b0, 1'b0});
                    end
                end else if (a_opcode == 3'd4) begin
                    for (int i = 0; i < LB; i++) begin
                        logic [31:0]  k;
                        logic [127:0] w;
                        k = (a_address >> 4) + 32'(i);
                        w = smem.exists(k) ? smem[k] : 128'd0;
                        if (cur_bad && i == 2) d_q.push_back({3'd0, 128'hBAD, 1'b0, 1'b0});
                        d_q.push_back({3'd1, w, 1'(i == cur_deny), 1'b0});
                    end
                end
            end

            if (d_valid && d_ready && d_q.size() > 0) begin
                void'(d_q.pop_front());
                if (d_opcode == exp_dop && d_rem > 0) d_rem--;
            end

            if (rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", rsp_err, exp_err);
                if (rsp_ready) outstanding = 0;
            end

            if (req_valid && req_ready) begin
                logic [31:0] line, base;
                line        = req_addr & ~32'h3F;
                base        = line >> 4;
                outstanding = 1;
                cur_deny    = deny_beat;
                cur_bad     = inject_bad;
                if (req_wr) begin
                    for (int i = 0; i < LB; i++) begin
                        a_exp.push_back({3'd0, line, req_wdata[128*i +: 128]});
                        ref_mem[base + 32'(i)] = req_wdata[128*i +: 128];
                    end
                    exp_rdata = req_wdata;
                    exp_err   = 1'b0;
                    d_rem     = 1;
                    exp_dop   = 3'd0;
                end else begin
                    a_exp.push_back({3'd4, line, 128'd0});
                    for (int i = 0; i < LB; i++) begin
                        logic [31:0] k;
                        k = base + 32'(i);
                        exp_rdata[128*i +: 128] = ref_mem.exists(k) ? ref_mem[k] : 128'd0;
                    end
                    exp_err = (deny_beat >= 0 && deny_beat < LB) || inject_bad;
                    d_rem   = LB;
                    exp_dop = 3'd1;
                end
            end
        end
    end

    task automatic send(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                        input int hold, output int lat, output logic [LW-1:0] rd,
                        output logic re);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_timeout", rsp_valid, 1'b1);
        rd = rsp_rdata;
        re = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    logic [LW-1:0] line0, wd, rd;
    logic          re;
    int            lat;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0; d_param = '0;
        d_size = '0; d_source = '0; d_sink = '0; d_denied = 1'b0; d_corrupt = 1'b0;
        d_data = '0;
        line0 = {{4{32'h4444_4444}}, {4{32'h3333_3333}}, {4{32'h2222_2222}},
                 {4{32'h1111_1111}}};

        repeat (3) @(negedge clk);
        chk("rst_hs", {a_valid, d_ready, rsp_valid, req_ready, rsp_err}, 5'b00010);
        chk("rst_a_fields", {a_opcode, a_param, a_size, a_source, a_address, a_mask,
                             a_corrupt}, {3'd0, 3'd0, 8'd6, 3'd0, 32'd0, 16'd0, 1'b0});
        chk("rst_a_data", a_data, 128'd0);
        chk("rst_rdata", rsp_rdata, '0);
        rst = 1'b0;

        // Directed write then read-back, no stalls.
        send(1'b1, 32'h8000_0040, line0, 0, lat, rd, re);
        chk("wr_latency", 32'(lat), 32'd6);
        chk("wr_err", re, 1'b0);
        chk("mem_0x40", smem[32'h0800_0004], {4{32'h1111_1111}});
        chk("mem_0x70", smem[32'h0800_0007], {4{32'h4444_4444}});
        send(1'b0, 32'h8000_0047, '0, 0, lat, rd, re);
        chk("rd_latency", 32'(lat), 32'd6);
        chk("rd_line", rd, line0);
        chk("rd_beat3", rd[3*128 +: 128], {4{32'h4444_4444}});

        // Stalls plus a held response, then random traffic.
        stall_en = 1;
        send(1'b0, 32'h8000_0040, '0, 5, lat, rd, re);
        chk("stall_rd_line", rd, line0);
        chk("stall_rd_err", re, 1'b0);
        for (int t = 0; t < 16; t++) begin
            for (int j = 0; j < LW / 32; j++) wd[32*j +: 32] = $urandom;
            send(1'($urandom_range(0, 1)),
                 32'h1000_0000 + (32'($urandom_range(0, 3)) << 6) + 32'($urandom_range(0, 63)),
                 wd, $urandom_range(0, 5), lat, rd, re);
        end

        // Denied data beat.
        deny_beat = 2;
        send(1'b0, 32'h8000_0040, '0, 0, lat, rd, re);
        chk("deny_err", re, 1'b1);
        chk("deny_line", rd, line0);
        deny_beat = -1;

        // Stray AccessAck in the middle of the data beats.
        inject_bad = 1;
        send(1'b0, 32'h8000_0040, '0, 0, lat, rd, re);
        chk("bad_op_err", re, 1'b1);
        chk("bad_op_line", rd, line0);
        inject_bad = 0;

        // Reset while the third Put beat is on the bus.
        stall_en = 0;
        begin
            int base, n;
            @(negedge clk);
            base = a_fire_cnt;
            req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h2000_0000;
            req_wdata = {16{32'hDEAD_BEEF}};
            @(negedge clk);
            req_valid = 1'b0;
            n = 0;
            while (a_fire_cnt - base < 2 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rst_mid_reach", 32'(a_fire_cnt - base), 32'd2);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_mid_a_valid", a_valid, 1'b0);
            chk("rst_mid_req_ready", req_ready, 1'b1);
        end
        send(1'b0, 32'h8000_0040, '0, 0, lat, rd, re);
        chk("post_rst_latency", 32'(lat), 32'd6);
        chk("post_rst_line", rd, line0);
        chk("post_rst_err", re, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tl_line_mst.md
# tl_line_mst

TileLink-UL master that moves one cache line between a local requester and a TileLink slave such as the testbench memory model. A write is a PutFullData burst. A read is a single Get whose AccessAckData beats are assembled into a line buffer. It sits between the core-side refill/writeback logic and the 128-bit TileLink A/D channels, and is the initiator counterpart of the slave memory.

## Interface
- LINE_BEATS, 4: beats per line, 128 bits each; power of two, 1..16. a_size = log2(16*LINE_BEATS) (6 by default).
- SRC_ID, 0: value driven on tlmst_a_source (3 bits).
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- req_valid / req_ready  in/out  1  request handshake.
- req_wr  in  1  1 = write line (Put), 0 = read line (Get).
- req_addr  in  32  line address; low log2(16*LINE_BEATS) bits ignored, driven as 0.
- req_wdata  in  128*LINE_BEATS  write line; beat i = bits [128*i +: 128].
- rsp_valid / rsp_ready  out/in  1  completion handshake.
- rsp_rdata  out  128*LINE_BEATS  read line, same beat packing as req_wdata.
- rsp_err  out  1  any D beat of the transaction had denied or corrupt set.
- tlmst_a_opcode out 3, a_param out 3, a_size out 8, a_source out 3, a_address out 32, a_mask out 16, a_data out 128, a_corrupt out 1, a_valid out 1, a_ready in 1: channel A.
- tlmst_d_opcode in 3, d_param in 2, d_size in 8, d_source in 3, d_sink in 3, d_denied in 1, d_data in 128, d_corrupt in 1, d_valid in 1, d_ready out 1: channel D.

## Operation
- States:
  - IDLE: req_ready=1. On req_valid: latch addr, wr and wdata into the line buffer; clear beat_cnt and err; go to PUT if wr, else GET.
  - PUT: a_valid=1, opcode 0 (PutFullData), mask 16'hFFFF, data = buffer beat beat_cnt, address = latched line address on every beat. On an A handshake, beat_cnt++. On the handshake with beat_cnt==LINE_BEATS-1, clear beat_cnt and go to PUT_ACK.
  - PUT_ACK: d_ready=1. On a D handshake with opcode 0 (AccessAck): err |= denied|corrupt; go to RSP.
  - GET: a_valid=1, opcode 4 (Get), mask all ones, data 0. On an A handshake, go to GET_DATA.
  - GET_DATA: d_ready=1. Each D handshake with opcode 1 (AccessAckData) writes d_data into buffer beat beat_cnt, beat_cnt++, err |= denied|corrupt. On the last beat, go to RSP.
  - RSP: rsp_valid=1; rsp_rdata = buffer. On rsp_ready, go to IDLE.
- D beats with an unexpected opcode while d_ready=1 are consumed: err is set, buffer and beat_cnt are unchanged, and the state is unchanged.
- d_ready=0 outside PUT_ACK/GET_DATA. No D beat may be consumed in PUT, including during the last A beat.
- Constant A fields: param 0, size log2(16*LINE_BEATS), source SRC_ID, corrupt 0. D source/sink/param/size are ignored.
- At most one transaction outstanding. req_ready=0 in every state but IDLE.
- beat_cnt is log2(LINE_BEATS)+1 bits wide; compare against LINE_BEATS-1, so there is no wrap.

## Timing
- Reset, effective on the next clk edge, from any state and mid-burst: state IDLE, beat_cnt 0, err 0, buffer 0. a_valid=0, d_ready=0, rsp_valid=0, req_ready=1, rsp_err=0, rsp_rdata=0. All A fields read 0 except the constants. An in-flight burst is abandoned without completion.
- All outputs are decoded from registered state/counter/buffer. There is no combinational path from inputs to outputs.
- Request accepted at edge 0 gives a_valid high in cycle 1.
- Write with a_ready=1 and an immediate ack: A beats in cycles 1..LINE_BEATS, AccessAck accepted in cycle LINE_BEATS+1 at the earliest, rsp_valid in the next cycle.
- Read: Get in cycle 1, data beats accepted from cycle 2, rsp_valid the cycle after the last beat.
- A-channel fields hold stable while a_valid=1 and a_ready=0.
- The req_valid and rsp_ready handshakes are standard valid/ready. rsp_valid stays high until accepted.

## Structure
- Shared package tl_pkg: A opcodes PUT_FULL=0 and GET=4, D opcodes ACK=0 and ACK_DATA=1, the 128-bit beat width, and the state enum.
- No sub-module required. The line buffer is an array of LINE_BEATS 128-bit registers inside the block.

## Test plan
- Write 4 beats, addr 0x8000_0040, beats 0x11.., 0x22.., 0x33.., 0x44.., a_ready=1 → four PutFullData beats (address 0x8000_0040, mask FFFF, size 6), one AccessAck, rsp_valid with rsp_err=0. Memory lines 0x40..0x70 match.
- Read back 0x8000_0040 → one Get (size 6), four AccessAckData beats, rsp_rdata equals the written line.
- Random a_ready and d_valid stalls, plus rsp_ready held low for 5 cycles → fields stable under stall, a single response, identical data.
- d_denied=1 on the read beat 2 → all 4 beats consumed, rsp_err=1.
- D AccessAck (opcode 0) injected during GET_DATA → beat consumed, rsp_err=1, beat_cnt unchanged.
- rst asserted during PUT beat 2 → next cycle a_valid=0, req_ready=1. A new read completes normally.
